// File: rtl/hazard_pkg.sv
// hazard_pkg -- shared sizing and helpers for the countdown hazard scoreboard.
//   NUM_REGS  architectural registers (register 0 is hard-wired, never busy)
//   RA_W      register address width
//   NUM_SRC   source operands checked per instruction
//   MAX_LAT   largest producer latency, in cycles until forwardable
//   WB_EXTRA  extra cycles from forwardable to register-file visible
//   CNT_W     countdown width; must hold MAX_LAT + WB_EXTRA
//   load_value() computes the countdown a producer installs, saturated to CNT_W.
package hazard_pkg;

  localparam int NUM_REGS = 32;
  localparam int RA_W     = 5;
  localparam int NUM_SRC  = 2;
  localparam int MAX_LAT  = 7;
  localparam int WB_EXTRA = 2;
  localparam int CNT_W    = 4;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Without forwarding a consumer must also wait for the register-file write,
  // so the producer's latency is stretched by wb_extra. Oversized values clamp
  // rather than wrap, so a long producer can never appear ready early.
  function automatic logic [CNT_W-1:0] load_value(input logic [CNT_W-1:0] lat,
                                                  input logic             fwd,
                                                  input int unsigned      wb_extra);
    int unsigned sum;
    sum = 32'(lat);
    if (!fwd) sum = sum + wb_extra;
    if (sum > 32'(CNT_MAX)) return CNT_MAX;
    return sum[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/hazard_scoreboard_sb_counter.sv
// sb_counter -- countdown for one architectural register.
//   clk, rst_n   pipeline clock, asynchronous active-low reset
//   load_en_i    an accepted instruction writes this register
//   load_val_i   countdown to install (already saturated)
//   cnt_o        cycles remaining before a consumer may read the register
//   busy_o       cnt_o is non-zero
module sb_counter
  import hazard_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_en_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             busy_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // A new producer overrides the running countdown; otherwise count to zero
  // and hold there.
  // NOTE: the default assignment at the top of every always_comb guarantees
  // each path assigns cnt_d, so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (load_en_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // NOTE: counters are real pipeline state, so they are reset; a reset in the
  // middle of a run must drop every pending producer at once.
  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together at the edge, independent of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard -- ID-stage RAW/WAW hazard detector built on a
// per-register countdown scoreboard. Handles variable-latency producers and
// any number of source operands.
//   clk, rst_n          pipeline clock, asynchronous active-low reset
//   issue_valid         ID holds a valid instruction
//   issue_wb_en         instruction writes a register
//   issue_dest          destination register
//   issue_lat           producer latency; 0 = result usable next issue
//   src_addr            packed source addresses, source 0 in the LSBs
//   src_valid           per-source use mask
//   forwarding_enable   forwarding mode; may change only while idle
//   hazard_detected     stall ID this cycle (freeze PC/IF-ID, bubble ID-EX)
//   src_hazard          per-source RAW stall reason
//   idle                no register has a pending producer
module hazard_scoreboard
  import hazard_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    issue_valid,
  input  logic                    issue_wb_en,
  input  logic [RA_W-1:0]         issue_dest,
  input  logic [CNT_W-1:0]        issue_lat,
  input  logic [NUM_SRC*RA_W-1:0] src_addr,
  input  logic [NUM_SRC-1:0]      src_valid,
  input  logic                    forwarding_enable,
  output logic                    hazard_detected,
  output logic [NUM_SRC-1:0]      src_hazard,
  output logic                    idle
);

  logic [NUM_REGS-1:0][CNT_W-1:0] cnt;
  logic [NUM_REGS-1:0]            busy;
  logic [CNT_W-1:0]               load_val;
  logic                           waw;
  logic                           write_en;

  assign load_val = load_value(issue_lat, forwarding_enable, WB_EXTRA);

  // Register 0 is hard-wired and never tracked.
  assign cnt[0]  = '0;
  assign busy[0] = 1'b0;

  // Only an accepted instruction updates the scoreboard; a stalled one is
  // re-presented and retried next cycle.
  assign write_en = issue_valid & ~hazard_detected & issue_wb_en & (issue_dest != '0);

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
    sb_counter u_cnt (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_en_i  (write_en && (issue_dest == RA_W'(r))),
      .load_val_i (load_val),
      .cnt_o      (cnt[r]),
      .busy_o     (busy[r])
    );
  end

  // Sources compare against the pre-update counters, so an instruction that
  // reads and writes the same register never stalls on itself.
  always_comb begin
    logic [RA_W-1:0] addr;
    addr       = '0;
    src_hazard = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      addr          = src_addr[i*RA_W +: RA_W];
      src_hazard[i] = src_valid[i] && (addr != '0) && (cnt[addr] != '0);
    end
  end

  // Write-after-write: a new producer may not finish before an older one to
  // the same register, so it waits until the old countdown is no longer than
  // its own.
  assign waw = issue_valid & issue_wb_en & (issue_dest != '0) & (cnt[issue_dest] > load_val);

  assign hazard_detected = issue_valid & ((|src_hazard) | waw);
  assign idle            = ~(|busy);

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard. A timestamp model (the absolute
// cycle at which each register becomes readable) predicts every output on
// every cycle; directed scenarios add hand-computed literal expectations.
module tb_hazard_scoreboard;
  import hazard_pkg::*;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    issue_valid;
  logic                    issue_wb_en;
  logic [RA_W-1:0]         issue_dest;
  logic [CNT_W-1:0]        issue_lat;
  logic [NUM_SRC*RA_W-1:0] src_addr;
  logic [NUM_SRC-1:0]      src_valid;
  logic                    forwarding_enable;
  logic                    hazard_detected;
  logic [NUM_SRC-1:0]      src_hazard;
  logic                    idle;

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .issue_valid       (issue_valid),
    .issue_wb_en       (issue_wb_en),
    .issue_dest        (issue_dest),
    .issue_lat         (issue_lat),
    .src_addr          (src_addr),
    .src_valid         (src_valid),
    .forwarding_enable (forwarding_enable),
    .hazard_detected   (hazard_detected),
    .src_hazard        (src_hazard),
    .idle              (idle)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // ready[r] = first cycle number in which a consumer of r may issue.
  int ready [NUM_REGS];
  int cyc = 0;

  function automatic int rem(input int r);
    if (r == 0) return 0;
    return (ready[r] > cyc) ? ready[r] - cyc : 0;
  endfunction

  function automatic int lval();
    int v;
    v = int'(issue_lat);
    if (!forwarding_enable) v = v + WB_EXTRA;
    return (v > 15) ? 15 : v;
  endfunction

  function automatic logic [NUM_SRC-1:0] m_src();
    logic [NUM_SRC-1:0] s;
    int a;
    s = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      a = int'(src_addr[i*RA_W +: RA_W]);
      s[i] = src_valid[i] && (rem(a) != 0);
    end
    return s;
  endfunction

  function automatic logic m_haz();
    logic waw;
    waw = issue_wb_en && (rem(int'(issue_dest)) > lval());
    return issue_valid && ((|m_src()) || waw);
  endfunction

  function automatic logic m_idle();
    for (int r = 0; r < NUM_REGS; r++) if (rem(r) != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic m_clear();
    for (int r = 0; r < NUM_REGS; r++) ready[r] = 0;
  endtask

  always @(posedge clk) begin
    if (!rst_n) m_clear();
    else if (issue_valid && !m_haz() && issue_wb_en && issue_dest != '0)
      ready[issue_dest] = cyc + 1 + lval();
    cyc++;
  end

  logic fwd_prev = 1'b1;

  always @(negedge clk) begin
    if (!rst_n) m_clear();
    check("model_src_hazard", 32'(src_hazard), 32'(m_src()));
    check("model_hazard", 32'(hazard_detected), 32'(m_haz()));
    check("model_idle", 32'(idle), 32'(m_idle()));
    if (forwarding_enable !== fwd_prev)
      assert (idle) else $error("forwarding_enable changed while scoreboard busy");
    fwd_prev = forwarding_enable;
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    issue_valid = 1'b0; issue_wb_en = 1'b0; issue_dest = '0; issue_lat = '0;
    src_addr = '0; src_valid = '0;
  endtask

  task automatic drive(input logic v, input logic wb, input int dest, input int lat,
                       input int s0, input int s1, input logic [1:0] sv);
    issue_valid = v; issue_wb_en = wb;
    issue_dest  = RA_W'(dest); issue_lat = CNT_W'(lat);
    src_addr    = {RA_W'(s1), RA_W'(s0)};
    src_valid   = sv;
  endtask

  // Holds the current instruction until it issues; reports stall cycles, the
  // src_hazard of the first stalled cycle and idle in the issuing cycle.
  task automatic wait_issue(output int n, output logic [1:0] sh, output logic id);
    n = 0; sh = '0; id = 1'b0;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (!hazard_detected) begin
        id = idle;
        step();
        idle_in();
        return;
      end
      if (n == 0) sh = src_hazard;
      n++;
      step();
    end
    check("wait_issue_timeout", 1, 0);
    idle_in();
  endtask

  int         n;
  logic [1:0] sh;
  logic       id;

  initial begin
    forwarding_enable = 1'b1;
    idle_in();
    rst_n = 1'b0;
    #1;
    check("reset_idle", 32'(idle), 1);
    check("reset_hazard", 32'(hazard_detected), 0);
    check("reset_src_hazard", 32'(src_hazard), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    // add r3 lat 0 then a consumer of r3: never stalls
    drive(1, 1, 3, 0, 0, 0, 2'b00); #1;
    check("add_r3_hazard", 32'(hazard_detected), 0);
    step();
    drive(1, 0, 0, 0, 3, 0, 2'b01); #1;
    check("use_r3_hazard", 32'(hazard_detected), 0);
    step();
    idle_in(); #1;
    check("after_add_idle", 32'(idle), 1);
    step();

    // load r5 lat 1 with forwarding: one stall cycle
    drive(1, 1, 5, 1, 0, 0, 2'b00); step();
    drive(1, 0, 0, 0, 5, 0, 2'b01);
    wait_issue(n, sh, id);
    check("ld_fwd_stalls", 32'(n), 1);
    check("ld_fwd_src_hazard", 32'(sh), 2'b01);
    check("ld_fwd_idle_at_issue", 32'(id), 1);

    // same load without forwarding: 1 + 2 = 3 stall cycles
    forwarding_enable = 1'b0;
    drive(1, 1, 5, 1, 0, 0, 2'b00); step();
    drive(1, 0, 0, 0, 5, 0, 2'b01); #1;
    check("ld_nofwd_busy", 32'(idle), 0);
    wait_issue(n, sh, id);
    check("ld_nofwd_stalls", 32'(n), 3);
    check("ld_nofwd_idle_at_issue", 32'(id), 1);

    // 14 + 2 = 16 must saturate to 15 rather than wrap
    drive(1, 1, 4, 14, 0, 0, 2'b00); step();
    drive(1, 0, 0, 0, 4, 0, 2'b01);
    wait_issue(n, sh, id);
    check("sat_stalls", 32'(n), 15);
    forwarding_enable = 1'b1;

    // div r7 lat 7 then add r7 lat 0: WAW stall of 7
    drive(1, 1, 7, 7, 0, 0, 2'b00); step();
    drive(1, 1, 7, 0, 0, 0, 2'b00);
    wait_issue(n, sh, id);
    check("waw_stalls", 32'(n), 7);

    // r7 busy again; unused src r7 plus clean src r2 must not stall
    drive(1, 1, 7, 7, 0, 0, 2'b00); step();
    drive(1, 0, 0, 0, 7, 2, 2'b10); #1;
    check("masked_src_hazard", 32'(hazard_detected), 0);
    check("masked_src_vector", 32'(src_hazard), 0);
    step();

    // hazard on source 1 only
    drive(1, 1, 6, 2, 0, 0, 2'b00); step();
    drive(1, 0, 0, 0, 1, 6, 2'b11);
    wait_issue(n, sh, id);
    check("src1_stalls", 32'(n), 2);
    check("src1_src_hazard", 32'(sh), 2'b10);

    // WAW boundary: remaining count equal to the new load value is allowed
    drive(1, 1, 8, 3, 0, 0, 2'b00); step();
    drive(1, 1, 8, 3, 0, 0, 2'b00); #1;
    check("waw_equal_no_stall", 32'(hazard_detected), 0);
    step();
    idle_in();
    for (int k = 0; k < 20; k++) begin
      if (idle) break;
      step();
    end
    check("drain_idle", 32'(idle), 1);

    // writes to r0 are never tracked
    drive(1, 1, 0, 7, 0, 0, 2'b00); #1;
    check("r0_write_hazard", 32'(hazard_detected), 0);
    step();
    drive(1, 0, 0, 0, 0, 0, 2'b01); #1;
    check("r0_read_hazard", 32'(hazard_detected), 0);
    check("r0_idle", 32'(idle), 1);
    step();
    idle_in();

    // load r9 lat 7, reset in cycle 3 drops it immediately
    drive(1, 1, 9, 7, 0, 0, 2'b00); step();
    idle_in(); step(); step();
    drive(1, 0, 0, 0, 9, 0, 2'b01); #1;
    check("pre_reset_hazard", 32'(hazard_detected), 1);
    rst_n = 1'b0; #1;
    check("mid_reset_idle", 32'(idle), 1);
    check("mid_reset_hazard", 32'(hazard_detected), 0);
    step();
    rst_n = 1'b1; #1;
    check("post_reset_hazard", 32'(hazard_detected), 0);
    step();
    idle_in();
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the ID-stage hazard detector of the multicycle MIPS pipeline.
- Replaces per-stage destination comparison with a per-register countdown scoreboard, so variable-latency producers (loads, mul/div) and any source-operand count are handled.
- Sits in ID.
- Produces the stall that freezes PC/IF-ID and bubbles ID-EX.

Parameters:
NUM_REGS, 32, architectural registers; register 0 never busy
RA_W, 5, register address width (clog2 NUM_REGS)
NUM_SRC, 2, source operands checked per instruction
MAX_LAT, 7, largest producer latency (cycles until forwardable)
WB_EXTRA, 2, extra cycles from forwardable to register-file visible
CNT_W, 4, counter width; must hold MAX_LAT+WB_EXTRA

Ports:
clk  in  1  pipeline clock
rst_n  in  1  asynchronous active-low reset
issue_valid  in  1  ID holds a valid instruction
issue_wb_en  in  1  instruction writes a register
issue_dest  in  RA_W  destination register
issue_lat  in  CNT_W  producer latency; 0 = result usable next issue
src_addr  in  NUM_SRC*RA_W  packed source addresses, src 0 in LSBs
src_valid  in  NUM_SRC  per-source use mask (replaces single_src)
forwarding_enable  in  1  forwarding mode; quasi-static
hazard_detected  out  1  stall ID this cycle
src_hazard  out  NUM_SRC  per-source RAW stall reason
idle  out  1  all counters zero

Behaviour:
- State: cnt[r], CNT_W bits, r = 1..NUM_REGS-1. cnt[r] = cycles before a consumer may issue reading r. cnt[0] is constant 0.
- Reset (async, rst_n=0): all cnt = 0. Outputs: hazard_detected=0, src_hazard=0, idle=1.
- Outputs are combinational from cnt and current inputs, with zero-cycle latency.
- src_hazard[i] = src_valid[i] & (src_addr[i] != 0) & (cnt[src_addr[i]] != 0).
- WAW hazard: issue_valid & issue_wb_en & (issue_dest != 0) & (cnt[issue_dest] > load value). This keeps writeback to a register in order.
- hazard_detected = issue_valid & (|src_hazard | WAW).
- Accept = issue_valid & ~hazard_detected.
- Load value = issue_lat when forwarding_enable=1, else issue_lat + WB_EXTRA. Saturate at 2^CNT_W - 1.
- Each cycle, every non-zero cnt decrements by 1.
- On accept with issue_wb_en and issue_dest != 0, cnt[issue_dest] <= load value. This overrides the decrement in the same cycle.
- Load value 0 leaves the register non-busy.
- Sources are checked against pre-update cnt. An instruction whose src equals its own dest does not stall on itself.
- An instruction with src_valid=0 never stalls on RAW, regardless of src_addr.
- Stall release: a consumer re-presented every cycle issues exactly load-value cycles after the producer was accepted.
- forwarding_enable may change only while idle=1. Behaviour is undefined otherwise; the bench checks this with an assertion.
- Reset mid-operation clears all pending entries immediately. Subsequent issues do not stall.

Decomposition:
- Shared package hazard_pkg holds RA_W, NUM_REGS, CNT_W and the function load_value(lat, fwd, wb_extra) with saturation.
- One sub-module, sb_counter: one register's countdown with load/decrement/saturate, instantiated NUM_REGS-1 times by generate.
- The top level holds the source-compare muxes, the WAW compare and the OR-reductions.

Test Plan:
- Reset then issue add r3 (lat 0, fwd=1), next cycle a src r3 consumer -> hazard_detected=0 throughout.
- Load r5 lat 1, fwd=1, consumer src r5 next cycle -> stall exactly 1 cycle, src_hazard=01; issues in cycle 2.
- Same load with fwd=0 (WB_EXTRA=2) -> stall 3 cycles; idle returns to 1 after cycle 3.
- Div r7 lat 7, then add r7 lat 0 -> WAW stall 7 cycles. A src r7 with src_valid=0 and an unrelated src r2 -> no RAW stall.
- Writes to r0 with lat 7, then consumer src r0 -> never stalls; idle stays 1.
- Load r9 lat 7, assert rst_n=0 at cycle 3 -> idle=1 and hazard_detected=0 immediately; consumer of r9 issues at once after release.
